lane_rr_merge: RTL
==================

Name: lane_rr_merge

Overview:
- Downstream consumer of a per-lane interface array: collects NUM_LANES independent valid/ready lanes (one per array element, driven from generate loops) and merges them into a single registered output stream.
- Fair round-robin arbitration; each output beat is tagged with its source lane index.
- Maintains a free-running count of beats accepted.
- Sits between per-lane producers and any single-stream sink.

Parameters:
- NUM_LANES, 4, number of input lanes (≥1).
- DATA_W, 8, payload width per lane.
- LANE_W, $clog2(NUM_LANES) (min 1), width of lane tag.
- CNT_W, 16, width of accepted-beat counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  NUM_LANES  per-lane valid; bit i belongs to lane i.
- in_data  input  NUM_LANES*DATA_W  per-lane payload; lane i at [i*DATA_W +: DATA_W].
- in_ready  output  NUM_LANES  per-lane ready; combinational, one-hot or zero.
- out_valid  output  1  output beat present.
- out_data  output  DATA_W  payload of the held beat.
- out_lane  output  LANE_W  source lane of the held beat.
- out_ready  input  1  sink accepts the beat when high with out_valid.
- beat_count  output  CNT_W  number of input beats accepted since reset, wraps.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_lane=0, beat_count=0, rr_ptr=0. in_ready is 0 throughout any cycle where rst=1.
- load_en = !out_valid || out_ready. The output register is a single-entry pipeline stage; it may be refilled in the same cycle it drains.
- Grant selection (combinational):
  - Consider lanes rr_ptr, rr_ptr+1, … wrapping modulo NUM_LANES.
  - The first lane with in_valid=1 is granted (g).
  - No lane valid: no grant.
- in_ready[g] = load_en && grant exists. All other in_ready bits are 0. in_ready must not depend on out_valid of the same lane's data.
- Transfer on lane g: in_valid[g] && in_ready[g] at the edge. On that edge:
  - out_data <= lane g payload, out_lane <= g, out_valid <= 1;
  - rr_ptr <= (g+1) mod NUM_LANES;
  - beat_count <= beat_count+1, wrapping at 2^CNT_W.
- load_en=1 and no grant: out_valid <= 0. out_data and out_lane hold their values (don't-care when out_valid=0). rr_ptr is unchanged.
- load_en=0 (out_valid=1, out_ready=0): out_valid, out_data and out_lane hold stable. No in_ready is asserted.
- Latency: one cycle from input transfer to out_valid. Full throughput of one beat per cycle when out_ready stays high.
- Fairness: with all lanes continuously valid, grants rotate 0,1,…,N-1,0… Worst-case wait for a valid lane is NUM_LANES-1 transfers.
- Wrap-around: with rr_ptr=N-1, lane N-1 has priority, then 0, 1, …
- NUM_LANES=1: always grant lane 0 when valid; rr_ptr and out_lane stay 0.
- Reset mid-operation: a held beat is discarded (out_valid=0 next cycle) and no transfer is counted on the reset edge.
- Upstream rule: once in_valid[i] is asserted it stays asserted with stable data until in_ready[i]. The block does not check this.

Test Plan:
- Reset then idle: rst high for 2 cycles, then all in_valid=0 for 5 cycles -> out_valid=0, in_ready=0000, beat_count=0 throughout.
- Single lane: lane 2 valid with data 0xA5, out_ready=1 -> in_ready=0100 that cycle; next cycle out_valid=1, out_data=0xA5, out_lane=2, beat_count=1; rr_ptr=3.
- Full contention: all 4 lanes valid continuously (data 0x10+i), out_ready=1 for 8 cycles -> out_lane sequence 0,1,2,3,0,1,2,3 on consecutive cycles; beat_count=8.
- Backpressure: hold beat from lane 1 (0x3C) with out_ready=0 for 3 cycles while lanes 0 and 3 are valid -> out_data stays 0x3C, in_ready=0000. On the first cycle out_ready=1, lane 3 is granted (rr_ptr=2) and loaded the same edge the 0x3C beat drains.
- Pointer wrap and skip: rr_ptr=3, only lane 0 valid -> lane 0 granted, rr_ptr=1. Next cycle only lanes 0 and 2 valid -> lane 2 granted.
- Reset mid-stream and counter wrap: with CNT_W=4, 17 transfers -> beat_count=1. Then assert rst while out_valid=1 -> next cycle out_valid=0, beat_count=0, rr_ptr=0.

Source files
------------

// File: rtl/lane_rr_merge.sv
// rtl/lane_rr_merge.sv - round-robin merge of NUM_LANES valid/ready lanes into one registered, lane-tagged stream
module lane_rr_merge #(
   parameter int NUM_LANES = 4,
   parameter int DATA_W    = 8,
   parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
   parameter int CNT_W     = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_LANES-1:0]        in_valid,
   input  logic [NUM_LANES*DATA_W-1:0] in_data,
   output logic [NUM_LANES-1:0]        in_ready,
   output logic                        out_valid,
   output logic [DATA_W-1:0]           out_data,
   output logic [LANE_W-1:0]           out_lane,
   input  logic                        out_ready,
   output logic [CNT_W-1:0]            beat_count
);

   logic                 r_out_valid;
   logic [DATA_W-1:0]    r_out_data;
   logic [LANE_W-1:0]    r_out_lane;
   logic [CNT_W-1:0]     r_beat_count;
   logic [LANE_W-1:0]    r_rr_ptr;

   logic                 w_load_en;
   logic                 w_found;
   logic [LANE_W-1:0]    w_grant;
   logic [LANE_W-1:0]    w_next_ptr;
   logic [NUM_LANES-1:0] w_ready;
   logic                 w_xfer;
   logic [DATA_W-1:0]    w_grant_data;

   assign w_load_en = !r_out_valid || out_ready;

   // Scan lanes starting at the pointer; the first valid lane wins.
   always_comb begin
      int idx;
      w_found = 1'b0;
      w_grant = '0;
      idx     = 0;
      for (int k = 0; k < NUM_LANES; k++) begin
         idx = (int'(r_rr_ptr) + k) % NUM_LANES;
         if (!w_found && in_valid[idx]) begin
            w_found = 1'b1;
            w_grant = LANE_W'(idx);
         end
      end
   end

   always_comb begin
      w_ready = '0;
      if (!rst && w_load_en && w_found) begin
         w_ready[w_grant] = 1'b1;
      end
   end

   assign w_xfer       = |(in_valid & w_ready);
   assign w_grant_data = in_data[int'(w_grant)*DATA_W +: DATA_W];
   assign w_next_ptr   = LANE_W'((int'(w_grant) + 1) % NUM_LANES);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_lane   <= '0;
         r_beat_count <= '0;
         r_rr_ptr     <= '0;
      end else if (w_load_en) begin
         if (w_xfer) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= w_grant_data;
            r_out_lane   <= w_grant;
            r_rr_ptr     <= w_next_ptr;
            r_beat_count <= r_beat_count + CNT_W'(1);
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign in_ready   = w_ready;
   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_lane   = r_out_lane;
   assign beat_count = r_beat_count;

endmodule
